// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: shadow E/M/W destination records drive stall, flush and forward selects.
// Define HAZARD_MD_EN to build the mult/div busy counter and its hazard term.
module hazard_scoreboard #(
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_rs_use,
  input  logic              d_rt_use,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic              d_wen,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_use,
  input  logic              e_md_start,
  input  logic              e_md_div,
  output logic              stall,
  output logic              flush_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic [1:0]        fwd_rt_m,
  output logic              md_busy
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic [TW-1:0]     tnew;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
  } rec_t;

  rec_t rec_e, rec_m, rec_w;
  logic haz_rs, haz_rt, md_hazard;

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  function automatic logic hit(input rec_t r, input logic [REG_AW-1:0] a);
    return r.valid && (r.dst == a) && (a != '0);
  endfunction

  // Only the youngest matching producer matters; an older match is shadowed by it.
  function automatic logic [2:0] d_check(input logic used, input logic [REG_AW-1:0] a,
                                         input logic [TW-1:0] tuse,
                                         input rec_t re, input rec_t rm, input rec_t rw);
    logic [TW-1:0] tn;
    logic [1:0]    code;
    logic          found;
    tn    = '0;
    code  = 2'd0;
    found = 1'b0;
    if (hit(re, a)) begin
      found = 1'b1; tn = re.tnew; code = 2'd1;
    end else if (hit(rm, a)) begin
      found = 1'b1; tn = rm.tnew; code = 2'd2;
    end else if (hit(rw, a)) begin
      found = 1'b1; tn = rw.tnew; code = 2'd3;
    end
    if (!used || !found)  return 3'b000;
    else if (tn > tuse)   return 3'b100;
    else if (tn == '0)    return {1'b0, code};
    else                  return 3'b000;
  endfunction

  function automatic logic [1:0] e_check(input logic [REG_AW-1:0] a,
                                         input rec_t rm, input rec_t rw);
    if (hit(rm, a))      return (rm.tnew == '0) ? 2'd2 : 2'd0;
    else if (hit(rw, a)) return (rw.tnew == '0) ? 2'd3 : 2'd0;
    else                 return 2'd0;
  endfunction

  always_comb begin
    {haz_rs, fwd_rs_d} = d_check(d_rs_use, d_rs, d_tuse_rs, rec_e, rec_m, rec_w);
    {haz_rt, fwd_rt_d} = d_check(d_rt_use, d_rt, d_tuse_rt, rec_e, rec_m, rec_w);
    fwd_rs_e = e_check(rec_e.rs, rec_m, rec_w);
    fwd_rt_e = e_check(rec_e.rt, rec_m, rec_w);
    fwd_rt_m = (hit(rec_w, rec_m.rt) && rec_w.tnew == '0) ? 2'd3 : 2'd0;
  end

  assign stall   = haz_rs | haz_rt | md_hazard;
  assign flush_e = stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_e <= '0;
      rec_m <= '0;
      rec_w <= '0;
    end else begin
      if (stall) rec_e <= '0;
      else       rec_e <= {d_wen, d_dst, d_tnew, d_rs, d_rt};
      rec_m <= {rec_e.valid, rec_e.dst, dec_sat(rec_e.tnew), rec_e.rs, rec_e.rt};
      rec_w <= {rec_m.valid, rec_m.dst, dec_sat(rec_m.tnew), rec_m.rs, rec_m.rt};
    end
  end

  // Source fields past E are carried for completeness but only M.rt is consulted.
  logic unused_rec;
  assign unused_rec = ^{rec_m.rs, rec_w.rs, rec_w.rt};

`ifdef HAZARD_MD_EN
  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                md_cnt <= '0;
    else if (e_md_start)      md_cnt <= e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (md_cnt != '0)    md_cnt <= md_cnt - CNT_W'(1);
  end

  assign md_busy   = (md_cnt != '0) || e_md_start;
  assign md_hazard = d_md_use && md_busy;
`else
  logic unused_md;
  assign unused_md = ^{d_md_use, e_md_start, e_md_div,
                       (MULT_LAT != 0), (DIV_LAT != 0), (CNT_W != 0)};
  assign md_busy   = 1'b0;
  assign md_hazard = 1'b0;
`endif

endmodule
